// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: feeds a pipelined DSP slice to form signed dot products.
// Ports: clk, RST_N; in_valid/in_ready/in_a/in_b/in_last operand beats;
// dsp_a/dsp_b/dsp_opmode/dsp_ce/dsp_p to the slice; out_valid/out_ready/out_p/out_count result.
module dsp_mac_sequencer #(
  parameter int LAT     = 3,
  parameter int OPM_LAG = 1
) (
  input  logic               clk,
  input  logic               RST_N,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [17:0] in_a,
  input  logic signed [17:0] in_b,
  input  logic               in_last,
  output logic signed [17:0] dsp_a,
  output logic signed [17:0] dsp_b,
  output logic [7:0]         dsp_opmode,
  output logic               dsp_ce,
  input  logic [47:0]        dsp_p,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [47:0]        out_p,
  output logic [15:0]        out_count
);

  localparam logic [7:0] OP_FIRST = 8'h01;
  localparam logic [7:0] OP_NEXT  = 8'h09;
  localparam logic [7:0] OP_BUBL  = 8'h08;

  typedef enum logic [1:0] {
    IDLE, ACCUM, DRAIN, DONE
  } state_t;

  state_t state, state_nxt;

  logic           live;
  logic           acc;
  logic           last_acc;
  logic           first;
  logic           cap;
  logic [7:0]     op_nxt;
  logic [7:0]     slot_op;
  logic [7:0]     opm_dl [OPM_LAG];
  logic           slot_vld;
  logic           slot_last;
  logic [LAT-1:0] tag_vld;
  logic [LAT-1:0] tag_last;
  logic [15:0]    cnt;
  logic [15:0]    cnt_nxt;

  assign acc        = in_valid & in_ready;
  assign last_acc   = acc & in_last;
  assign first      = (state == IDLE);
  // slot tag rides with dsp_a, so the exit edge sees the slot's settled P
  assign cap        = tag_vld[LAT-1] & tag_last[LAT-1];
  assign dsp_ce     = RST_N;
  assign dsp_opmode = opm_dl[OPM_LAG-1];

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      live  <= 1'b0;
    end else begin
      state <= state_nxt;
      live  <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (last_acc)  state_nxt = DRAIN;
        else if (acc)  state_nxt = ACCUM;
      end
      ACCUM: begin
        if (last_acc)  state_nxt = DRAIN;
      end
      DRAIN: begin
        if (cap)       state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready  = live & ((state == IDLE) | (state == ACCUM));
    out_valid = (state == DONE);
  end

  always_comb begin
    op_nxt = OP_BUBL;
    unique case (1'b1)
      acc & first:  op_nxt = OP_FIRST;
      acc & !first: op_nxt = OP_NEXT;
      default:      op_nxt = OP_BUBL;
    endcase
  end

  always_comb begin
    cnt_nxt = cnt + 16'd1;
    if (first)     cnt_nxt = 16'd1;
    else if (&cnt) cnt_nxt = cnt;
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      dsp_a     <= '0;
      dsp_b     <= '0;
      slot_op   <= '0;
      slot_vld  <= 1'b0;
      slot_last <= 1'b0;
      tag_vld   <= '0;
      tag_last  <= '0;
      cnt       <= '0;
      out_count <= '0;
      out_p     <= '0;
      for (int i = 0; i < OPM_LAG; i++) opm_dl[i] <= '0;
    end else begin
      dsp_a       <= acc ? in_a : 18'sd0;
      dsp_b       <= acc ? in_b : 18'sd0;
      slot_op     <= op_nxt;
      slot_vld    <= acc;
      slot_last   <= last_acc;
      tag_vld[0]  <= slot_vld;
      tag_last[0] <= slot_last;
      for (int i = 1; i < LAT; i++) begin
        tag_vld[i]  <= tag_vld[i-1];
        tag_last[i] <= tag_last[i-1];
      end
      opm_dl[0] <= slot_op;
      for (int i = 1; i < OPM_LAG; i++) opm_dl[i] <= opm_dl[i-1];
      if (acc)      cnt       <= cnt_nxt;
      if (last_acc) out_count <= cnt_nxt;
      if (cap)      out_p     <= dsp_p;
    end
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb_dsp_mac_sequencer: randomized bench with a slice model and a dot-product model.
// Drives inputs on the falling edge and samples outputs there.
module tb_dsp_mac_sequencer;

  logic               clk = 1'b0;
  logic               RST_N = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [17:0] in_a = '0;
  logic signed [17:0] in_b = '0;
  logic               in_last = 1'b0;
  logic signed [17:0] dsp_a;
  logic signed [17:0] dsp_b;
  logic [7:0]         dsp_opmode;
  logic               dsp_ce;
  logic [47:0]        dsp_p;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [47:0]        out_p;
  logic [15:0]        out_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dsp_mac_sequencer #(.LAT(3), .OPM_LAG(1)) dut (
    .clk(clk), .RST_N(RST_N),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode),
    .dsp_ce(dsp_ce), .dsp_p(dsp_p),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_count(out_count)
  );

  // slice: A/B reg, M reg with opmode reg, P reg; X=M if op[0], Z=P if op[3]
  logic signed [17:0] s_a = '0;
  logic signed [17:0] s_b = '0;
  logic signed [35:0] s_m = '0;
  logic [7:0]         s_op = '0;
  logic [47:0]        s_p = '0;

  always @(posedge clk) begin
    if (dsp_ce) begin
      s_a  <= dsp_a;
      s_b  <= dsp_b;
      s_m  <= s_a * s_b;
      s_op <= dsp_opmode;
      s_p  <= (s_op[0] ? {{12{s_m[35]}}, s_m} : 48'd0)
            + (s_op[3] ? s_p : 48'd0);
    end
  end
  assign dsp_p = s_p;

  task automatic beat(input logic signed [17:0] a,
                      input logic signed [17:0] b,
                      input logic last);
    int k;
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    k = 0;
    while (!in_ready && k < 100) begin
      @(negedge clk); k++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL beat_accept: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic collect(output int lat, output logic [47:0] p,
                         output logic [15:0] c);
    in_valid = 1'b0; in_last = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    if (!out_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL result_timeout: out_valid=%0b required 1", out_valid);
    end
    p = out_p; c = out_count;
  endtask

  task automatic handshake();
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid, dsp_ce, dsp_opmode, dsp_a, dsp_b} !== '0) begin
      n_bad++;
      $display("FAIL reset_ctl: rdy=%0b ov=%0b ce=%0b op=%0h a=%0h b=%0h required all 0",
               in_ready, out_valid, dsp_ce, dsp_opmode, dsp_a, dsp_b);
    end
    n_cmp++;
    if ({out_p, out_count} !== '0) begin
      n_bad++;
      $display("FAIL reset_out: p=%0h cnt=%0h required 0", out_p, out_count);
    end
    RST_N = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL ready_after_release: in_ready=%0b required 0", in_ready);
    end
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || dsp_ce !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_first_edge: in_ready=%0b ce=%0b required 1 1", in_ready, dsp_ce);
    end
  endtask

  task automatic test_basic();
    int lat; logic [47:0] p; logic [15:0] c;
    beat(18'sd2, 18'sd3, 1'b0);
    beat(18'sd4, 18'sd5, 1'b0);
    beat(-18'sd1, 18'sd7, 1'b1);
    collect(lat, p, c);
    n_cmp++;
    if (p !== 48'd19 || c !== 16'd3) begin
      n_bad++;
      $display("FAIL basic_result: p=%0d cnt=%0d required 19 3", p, c);
    end
    n_cmp++;
    if (lat != 4) begin
      n_bad++;
      $display("FAIL basic_latency: edges=%0d required 4", lat);
    end
    handshake();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_release: ov=%0b rdy=%0b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_single();
    int lat; logic [47:0] p; logic [15:0] c;
    beat(-18'sd131072, -18'sd131072, 1'b1);
    collect(lat, p, c);
    n_cmp++;
    if (p !== 48'h0004_0000_0000 || c !== 16'd1) begin
      n_bad++;
      $display("FAIL single_result: p=%0h cnt=%0d required 400000000 1", p, c);
    end
    handshake();
  endtask

  task automatic test_gap();
    int lat; logic [47:0] p; logic [15:0] c;
    logic [7:0] want [3];
    want[0] = 8'h01; want[1] = 8'h08; want[2] = 8'h08;
    beat(18'sd1, 18'sd1, 1'b0);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (dsp_opmode !== want[i]) begin
        n_bad++;
        $display("FAIL gap_opmode%0d: op=%0h required %0h", i, dsp_opmode, want[i]);
      end
    end
    beat(18'sd2, 18'sd2, 1'b1);
    n_cmp++;
    if (dsp_opmode !== 8'h08) begin
      n_bad++;
      $display("FAIL gap_opmode3: op=%0h required 08", dsp_opmode);
    end
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if (dsp_opmode !== 8'h09) begin
      n_bad++;
      $display("FAIL gap_opmode_last: op=%0h required 09", dsp_opmode);
    end
    collect(lat, p, c);
    n_cmp++;
    if (p !== 48'd5 || c !== 16'd2) begin
      n_bad++;
      $display("FAIL gap_result: p=%0d cnt=%0d required 5 2", p, c);
    end
    handshake();
  endtask

  task automatic test_hold();
    int lat; logic [47:0] p; logic [15:0] c;
    beat(18'sd10, -18'sd3, 1'b0);
    beat(18'sd6, 18'sd6, 1'b1);
    collect(lat, p, c);
    n_cmp++;
    if (p !== 48'd6 || c !== 16'd2) begin
      n_bad++;
      $display("FAIL hold_result: p=%0d cnt=%0d required 6 2", p, c);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_last = 1'b1;
      in_a = 18'($urandom); in_b = 18'($urandom);
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_p !== 48'd6 || out_count !== 16'd2 || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_cycle%0d: ov=%0b p=%0d cnt=%0d rdy=%0b required 1 6 2 0",
                 i, out_valid, out_p, out_count, in_ready);
      end
    end
    handshake();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL hold_release: ov=%0b rdy=%0b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [47:0] p; logic [15:0] c;
    beat(18'sd100, 18'sd100, 1'b0);
    beat(18'sd7, 18'sd9, 1'b0);
    in_valid = 1'b0; in_last = 1'b0;
    RST_N = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, dsp_opmode, dsp_a} !== '0) begin
      n_bad++;
      $display("FAIL midreset_async: rdy=%0b ov=%0b op=%0h a=%0h required 0",
               in_ready, out_valid, dsp_opmode, dsp_a);
    end
    repeat (2) @(negedge clk);
    RST_N = 1'b1;
    @(posedge clk); @(negedge clk);
    beat(18'sd3, 18'sd3, 1'b1);
    collect(lat, p, c);
    n_cmp++;
    if (p !== 48'd9 || c !== 16'd1 || lat != 4) begin
      n_bad++;
      $display("FAIL midreset_result: p=%0d cnt=%0d edges=%0d required 9 1 4", p, c, lat);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    int lat; logic [47:0] p; logic [15:0] c;
    beat(18'sd1, 18'sd2, 1'b1);
    collect(lat, p, c);
    n_cmp++;
    if (p !== 48'd2 || c !== 16'd1) begin
      n_bad++;
      $display("FAIL b2b_first: p=%0d cnt=%0d required 2 1", p, c);
    end
    handshake();
    beat(18'sd5, 18'sd5, 1'b1);
    collect(lat, p, c);
    n_cmp++;
    if (p !== 48'd25 || c !== 16'd1 || lat != 4) begin
      n_bad++;
      $display("FAIL b2b_second: p=%0d cnt=%0d edges=%0d required 25 1 4", p, c, lat);
    end
    handshake();
  endtask

  task automatic test_random();
    int lat; logic [47:0] p; logic [15:0] c;
    logic signed [17:0] a, b;
    longint sum;
    int n;
    logic [47:0] want;
    for (int v = 0; v < 15; v++) begin
      n = $urandom_range(1, 6);
      sum = 0;
      for (int i = 0; i < n; i++) begin
        if (i > 0) begin
          in_valid = 1'b0;
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); @(negedge clk);
          end
        end
        a = 18'($urandom); b = 18'($urandom);
        sum += longint'(a) * longint'(b);
        beat(a, b, i == n - 1);
      end
      want = sum[47:0];
      collect(lat, p, c);
      n_cmp++;
      if (p !== want || c !== 16'(n) || lat != 4) begin
        n_bad++;
        $display("FAIL random_vec%0d: p=%0h cnt=%0d edges=%0d required %0h %0d 4",
                 v, p, c, lat, want, n);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      handshake();
    end
  endtask

  task automatic test_saturate();
    int lat; logic [47:0] p; logic [15:0] c;
    for (int i = 0; i < 65537; i++) beat(18'sd1, 18'sd1, i == 65536);
    collect(lat, p, c);
    n_cmp++;
    if (p !== 48'd65537 || c !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL saturate: p=%0d cnt=%0h required 65537 ffff", p, c);
    end
    handshake();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_gap();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
